// File: rtl/dmem_pkg.sv
// Shared types and default configuration for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } dmem_state_t;

    localparam int DMEM_ADDR_W      = 10;
    localparam int DMEM_WAIT_STATES = 1;
    localparam int WAIT_W           = 3;

endpackage

// File: rtl/dmem_wait_counter.sv
// Loadable down-counter pacing SRAM wait states; 'last' flags count==1.
// Holds at zero; load takes priority over enable.
module dmem_wait_counter
    import dmem_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              en,
    input  logic [WAIT_W-1:0] load_val,
    output logic              last
);

    logic [WAIT_W-1:0] count_q;
    logic [WAIT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (en && (count_q != '0)) begin
            count_d = count_q - WAIT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign last = (count_q == WAIT_W'(1));

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage data-memory responder: one access per request, 2+WAIT_STATES cycles, stall held until DONE.
// DMEM_MISALIGN_TRAP_EN: misaligned requests skip the SRAM and complete next cycle with rsp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = DMEM_ADDR_W,
    parameter int WAIT_STATES = DMEM_WAIT_STATES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_rd,
    output logic              stall,
    output logic              rsp_valid,
    output logic              rsp_load,
    output logic [3:0]        rsp_rd,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_we,
    output logic [31:0]       sram_wdata,
    input  logic [31:0]       sram_rdata
);

    dmem_state_t       state_q, state_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [3:0]        rd_q, rd_d;
    logic              err_q, err_d;
    logic              cnt_load, cnt_en, cnt_last;
    logic              misalign;
    logic              unused_addr_bits;

`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Bits above the word index wrap; byte offset only matters for the trap.
    assign unused_addr_bits = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    dmem_wait_counter u_wait_counter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (WAIT_W'(WAIT_STATES)),
        .last     (cnt_last)
    );

    always_comb begin
        state_d   = state_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_d      = rd_q;
        err_d     = err_q;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        stall     = 1'b0;
        sram_we   = 1'b0;
        rsp_valid = 1'b0;
        rsp_load  = 1'b0;
        rsp_rd    = '0;
        rsp_rdata = '0;
        rsp_err   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall   = 1'b1;
                    we_d    = req_we;
                    addr_d  = req_addr[ADDR_W+1:2];
                    wdata_d = req_wdata;
                    rd_d    = req_rd;
                    err_d   = misalign;
                    state_d = misalign ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                stall    = 1'b1;
                sram_we  = we_q;
                cnt_load = 1'b1;
                state_d  = (WAIT_STATES > 0) ? WAIT : DONE;
            end
            WAIT: begin
                stall  = 1'b1;
                cnt_en = 1'b1;
                if (cnt_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                rsp_valid = 1'b1;
                rsp_load  = ~we_q & ~err_q;
                rsp_rd    = rd_q;
                rsp_rdata = (we_q | err_q) ? 32'd0 : sram_rdata;
                rsp_err   = err_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
        end
    end

    assign sram_addr  = addr_q;
    assign sram_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench: dut0 runs WAIT_STATES=1, dut1 runs WAIT_STATES=0, each with its own SRAM model.
module tb_dmem_responder;
    import dmem_pkg::*;

    typedef struct packed {
        logic        load;
        logic [3:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_init;
    logic        req_valid [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_rd    [2];
    logic        stall     [2];
    logic        rsp_valid [2];
    logic        rsp_load  [2];
    logic [3:0]  rsp_rd    [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic [9:0]  sram_addr [2];
    logic        sram_we   [2];
    logic [31:0] sram_wdata[2];
    logic [31:0] sram_rdata[2];

    logic [31:0] mem0 [1024];
    logic [31:0] mem1 [1024];

    exp_t        exp_q0[$];
    exp_t        exp_q1[$];
    int unsigned cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          we_cnt [2] = '{0, 0};
    int          rsp_cnt[2] = '{0, 0};
    int          quiet_viol = 0;
    logic [9:0]  we_addr[2];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_we(req_we[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .req_rd(req_rd[0]),
        .stall(stall[0]), .rsp_valid(rsp_valid[0]), .rsp_load(rsp_load[0]),
        .rsp_rd(rsp_rd[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .sram_addr(sram_addr[0]), .sram_we(sram_we[0]), .sram_wdata(sram_wdata[0]),
        .sram_rdata(sram_rdata[0])
    );

    dmem_responder #(.ADDR_W(10), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_we(req_we[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .req_rd(req_rd[1]),
        .stall(stall[1]), .rsp_valid(rsp_valid[1]), .rsp_load(rsp_load[1]),
        .rsp_rd(rsp_rd[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .sram_addr(sram_addr[1]), .sram_we(sram_we[1]), .sram_wdata(sram_wdata[1]),
        .sram_rdata(sram_rdata[1])
    );

    // Synchronous single-port SRAM models: read data registered, write at the clock edge.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 1024; i++) begin
                mem0[i] <= 32'd0;
                mem1[i] <= 32'hA000_0000 | 32'(i);
            end
        end else begin
            if (sram_we[0] === 1'b1) mem0[sram_addr[0]] <= sram_wdata[0];
            if (sram_we[1] === 1'b1) mem1[sram_addr[1]] <= sram_wdata[1];
        end
        sram_rdata[0] <= mem0[sram_addr[0]];
        sram_rdata[1] <= mem1[sram_addr[1]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitor: pops the scoreboard on every completion pulse.
    always @(negedge clk) begin
        exp_t e;
        bit   have;
        for (int d = 0; d < 2; d++) begin
            if (sram_we[d] === 1'b1) begin
                we_cnt[d]++;
                we_addr[d] = sram_addr[d];
            end
            if (rsp_valid[d] === 1'b1) begin
                rsp_cnt[d]++;
                have = (d == 0) ? (exp_q0.size() > 0) : (exp_q1.size() > 0);
                if (!have) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL dut%0d_rsp_unexpected: got rsp_valid=1 at cycle %0d, required no response", d, cyc);
                end else begin
                    if (d == 0) e = exp_q0.pop_front();
                    else        e = exp_q1.pop_front();
                    check($sformatf("dut%0d_rsp_cycle", d), 64'(cyc), 64'(e.cyc));
                    check($sformatf("dut%0d_rsp_load", d), 64'(rsp_load[d]), 64'(e.load));
                    check($sformatf("dut%0d_rsp_rd", d), 64'(rsp_rd[d]), 64'(e.rd));
                    check($sformatf("dut%0d_rsp_rdata", d), 64'(rsp_rdata[d]), 64'(e.rdata));
                    check($sformatf("dut%0d_rsp_err", d), 64'(rsp_err[d]), 64'(e.err));
                end
            end else if ((|{rsp_load[d], rsp_rd[d], rsp_rdata[d], rsp_err[d]}) !== 1'b0) begin
                quiet_viol++;
            end
        end
    end

    // Presents one request from a posedge+1 point and holds it until the stall releases.
    task automatic issue(input int d, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] rd, input int lat,
                         input logic e_load, input logic [31:0] e_rdata, input logic e_err);
        exp_t e;
        int   n;
        bit   done;
        e.load  = e_load;
        e.rd    = rd;
        e.rdata = e_rdata;
        e.err   = e_err;
        e.cyc   = cyc + 32'(lat);
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
        req_valid[d] = 1'b1;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_rd[d]    = rd;
        n    = 0;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (stall[d] === 1'b1) n++;
            else done = 1'b1;
        end
        if (!done) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d_stall_timeout: got stall still high after 20 cycles, required release", d);
        end
        check($sformatf("dut%0d_stall_cycles@%0h", d, addr), 64'(n), 64'(lat));
        @(posedge clk);
        #1;
        req_valid[d] = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1);
    end

    initial begin
        int w0;
        int r0;
        int unsigned c0;
        int busy;

        rst_n    = 1'b0;
        mem_init = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_we[d]    = 1'b0;
            req_addr[d]  = '0;
            req_wdata[d] = '0;
            req_rd[d]    = '0;
        end
        @(posedge clk);
        #1;
        mem_init = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("dut%0d_reset_outputs", d),
                  64'({stall[d], sram_we[d], rsp_valid[d], sram_addr[d], sram_wdata[d]}), 64'd0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Store then load with one wait state.
        w0 = we_cnt[0];
        issue(0, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'd0, 3, 1'b0, 32'd0, 1'b0);
        check("store40_we_pulses", 64'(we_cnt[0] - w0), 64'd1);
        check("store40_we_addr", 64'(we_addr[0]), 64'h10);
        check("store40_mem", 64'(mem0[16]), 64'hDEAD_BEEF);
        issue(0, 1'b0, 32'h0000_0040, 32'd0, 4'd5, 3, 1'b1, 32'hDEAD_BEEF, 1'b0);

        // Zero wait states: single load, then three back to back.
        issue(1, 1'b0, 32'h0000_0008, 32'd0, 4'd1, 2, 1'b1, 32'hA000_0002, 1'b0);
        c0 = cyc;
        r0 = rsp_cnt[1];
        issue(1, 1'b0, 32'h0000_000C, 32'd0, 4'd2, 2, 1'b1, 32'hA000_0003, 1'b0);
        issue(1, 1'b0, 32'h0000_0010, 32'd0, 4'd3, 2, 1'b1, 32'hA000_0004, 1'b0);
        issue(1, 1'b0, 32'h0000_0014, 32'd0, 4'd4, 2, 1'b1, 32'hA000_0005, 1'b0);
        check("b2b_elapsed_cycles", 64'(cyc - c0), 64'd9);
        check("b2b_rsp_pulses", 64'(rsp_cnt[1] - r0), 64'd3);

        // Address wrap: 0x1004 lands on word 1.
        issue(0, 1'b1, 32'h0000_1004, 32'h0000_1234, 4'd0, 3, 1'b0, 32'd0, 1'b0);
        check("wrap_we_addr", 64'(we_addr[0]), 64'h1);
        check("wrap_mem", 64'(mem0[1]), 64'h1234);
        issue(0, 1'b0, 32'h0000_0004, 32'd0, 4'd7, 3, 1'b1, 32'h0000_1234, 1'b0);

        // Misaligned store to 0x42.
        w0 = we_cnt[0];
`ifdef DMEM_MISALIGN_TRAP_EN
        issue(0, 1'b1, 32'h0000_0042, 32'hCAFE_F00D, 4'd2, 1, 1'b0, 32'd0, 1'b1);
        check("misalign_we_pulses", 64'(we_cnt[0] - w0), 64'd0);
        check("misalign_mem", 64'(mem0[16]), 64'hDEAD_BEEF);
`else
        issue(0, 1'b1, 32'h0000_0042, 32'hCAFE_F00D, 4'd2, 3, 1'b0, 32'd0, 1'b0);
        check("misalign_we_pulses", 64'(we_cnt[0] - w0), 64'd1);
        check("misalign_we_addr", 64'(we_addr[0]), 64'h10);
        check("misalign_mem", 64'(mem0[16]), 64'hCAFE_F00D);
`endif

        // Reset during ACCESS of a store to word 0x20: write must be dropped.
        req_valid[0] = 1'b1;
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h0000_0080;
        req_wdata[0] = 32'h5555_AAAA;
        req_rd[0]    = 4'd0;
        @(posedge clk);
        @(negedge clk);
        check("rst_access_we", 64'(sram_we[0]), 64'd1);
        rst_n        = 1'b0;
        req_valid[0] = 1'b0;
        #1;
        check("rst_outputs", 64'({stall[0], sram_we[0], rsp_valid[0], rsp_load[0], rsp_rd[0],
                                  rsp_err[0], sram_addr[0]}), 64'd0);
        check("rst_outputs_data", 64'({rsp_rdata[0], sram_wdata[0]}), 64'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_mem_unchanged", 64'(mem0[32]), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_release_idle_stall", 64'(stall[0]), 64'd0);
        @(posedge clk);
        #1;
        issue(0, 1'b0, 32'h0000_0080, 32'd0, 4'd9, 3, 1'b1, 32'd0, 1'b0);

        // Idle bus for ten cycles.
        busy = 0;
        w0   = we_cnt[0] + we_cnt[1];
        r0   = rsp_cnt[0] + rsp_cnt[1];
        repeat (10) begin
            @(negedge clk);
            if ((stall[0] | stall[1]) !== 1'b0) busy++;
        end
        check("idle_stall_cycles", 64'(busy), 64'd0);
        check("idle_we_pulses", 64'(we_cnt[0] + we_cnt[1] - w0), 64'd0);
        check("idle_rsp_pulses", 64'(rsp_cnt[0] + rsp_cnt[1] - r0), 64'd0);

        repeat (3) @(posedge clk);
        check("dut0_outstanding", 64'(exp_q0.size()), 64'd0);
        check("dut1_outstanding", 64'(exp_q1.size()), 64'd0);
        check("rsp_quiet_when_invalid", 64'(quiet_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Responder end of the memory-stage data-memory interface. Accepts one load or store request per instruction from the memory-stage controller: the request strobe, `mem_w_en`, the ALU-computed byte address, store data and the destination register tag. Sequences the access onto a single-port synchronous SRAM with configurable wait states, holds the pipeline with `stall` until the access completes, and returns load data tagged for write-back.

## Interface
- ADDR_W, 10, SRAM word-address width (memory is 2^ADDR_W 32-bit words).
- WAIT_STATES, 1, extra SRAM cycles per access, legal range 0..7.

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  memory stage holds a load/store this cycle
- req_we  in  1  1 = store (driven from `mem_w_en`), 0 = load
- req_addr  in  32  byte address from the ALU
- req_wdata  in  32  store data
- req_rd  in  4  load destination register
- stall  out  1  hold the pipeline (feeds `stall_pc` and the stage enables)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_load  out  1  completed access was a load (write-back enable)
- rsp_rd  out  4  tag of the completed access
- rsp_rdata  out  32  load data, 0 for stores
- rsp_err  out  1  misaligned-access flag (see Configuration)
- sram_addr  out  ADDR_W  word address
- sram_we  out  1  SRAM write strobe
- sram_wdata  out  32  SRAM write data
- sram_rdata  in  32  SRAM read data, valid the cycle after the address is presented, held while the address is stable

## Operation
- FSM states: IDLE, ACCESS, WAIT, DONE.
- IDLE: when req_valid=1, latch we/addr/wdata/rd; go to ACCESS. Otherwise stay in IDLE.
- ACCESS: drive sram_addr = addr_q[ADDR_W+1:2]. sram_we = we_q for this cycle only. Load the wait counter with WAIT_STATES. Go to WAIT if WAIT_STATES>0, else go to DONE.
- WAIT: keep sram_addr stable with sram_we=0. Decrement the counter. Go to DONE on the cycle the counter reads 1.
- DONE: rsp_valid=1, rsp_load=~we_q, rsp_rd=rd_q. rsp_rdata = sram_rdata for loads and 0 for stores. Unconditionally return to IDLE.
- stall = (IDLE & req_valid) | ACCESS | WAIT. It is combinational in IDLE, so the requesting instruction never advances before capture. It is low in DONE, so the pipeline advances at the end of DONE.
- Address upper bits above ADDR_W+1 are ignored; out-of-range addresses wrap modulo memory size.
- rsp_* outputs are 0 whenever the state is not DONE.
- All outputs reset to 0. State resets to IDLE and the counter to 0.

## Timing
- Request seen in cycle 0 (IDLE), ACCESS in cycle 1, WAIT in cycles 2..1+WAIT_STATES, DONE in cycle 2+WAIT_STATES.
- stall is high for 2+WAIT_STATES cycles. The next request is first sampled in cycle 3+WAIT_STATES.
- Back-to-back requests: the request held in DONE is the one already served. It is not re-accepted, because the FSM leaves DONE unconditionally and the pipeline presents the next instruction in the following cycle.
- The store commits at the clock edge ending ACCESS.
- Reset asserted before that edge: the store is dropped. Reset asserted after it: the store has committed and no response is produced.
- req_valid dropping while stalled is illegal; the latched request completes regardless.

## Configuration
- DMEM_MISALIGN_TRAP_EN defined:
  - A request with req_addr[1:0]≠0 skips ACCESS and WAIT (IDLE→DONE).
  - No SRAM write occurs.
  - DONE reports rsp_err=1 and rsp_rdata=0. stall is high for 1 cycle.
  - rsp_load is forced to 0 so write-back is suppressed.
- Undefined: req_addr[1:0] is ignored (word-aligned access) and rsp_err is tied to 0.

## Structure
- Package `dmem_pkg`:
  - state enum `dmem_state_t` (IDLE, ACCESS, WAIT, DONE)
  - default ADDR_W and WAIT_STATES constants
  - WAIT_W = 3 counter width
- One sub-module, `dmem_wait_counter`: loadable down-counter with load, enable and a `last` (count==1) output. It is instantiated once.

## Test plan
- Store then load, WAIT_STATES=1: store 0xDEADBEEF at 0x0000_0040, then load 0x40 with rd=5.
  - Store: sram_we pulses once at word address 0x10 with stall high for 3 cycles.
  - Load: rsp_valid in cycle 3, rsp_rdata=0xDEADBEEF, rsp_rd=5, rsp_load=1.
- WAIT_STATES=0: load from 0x8 → stall high for 2 cycles and DONE in cycle 2. Issue 3 back-to-back loads → exactly 3 rsp_valid pulses 3 cycles apart.
- Wrap: store 0x1234 to 0x0000_1004 with ADDR_W=10 → the write lands at word address 1. A load from 0x4 returns 0x1234.
- Misaligned store to 0x42:
  - With DMEM_MISALIGN_TRAP_EN: sram_we never asserts, rsp_err=1 in cycle 1, stall for 1 cycle.
  - Without it: the write goes to word 0x10 and rsp_err=0.
- Reset mid-access: assert rst_n low in cycle 1 of a store → the SRAM word is unchanged, all outputs read 0, and the state is IDLE after release.
- Idle bus: req_valid=0 for 10 cycles → stall, sram_we and rsp_valid all stay 0.
